wb_stage_p: RTL and testbench
=============================

# wb_stage_p

Parametrised write-back stage for the MIPS R2000 pipeline. It contains its own MEM/WB pipeline register with stall and flush control. It performs load byte/halfword extraction with sign or zero extension and selects between ALU, memory and link results. It suppresses writes to `$0`, holds a one-entry history of the last committed write for ID-stage bypass across the register-file write edge, and counts retired instructions.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 32: retired-instruction counter width.
- `BIG_ENDIAN`, default 0: byte-lane numbering for sub-word loads; 0 = little-endian, 1 = big-endian.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the MEM/WB register.
- `flush` in 1: load a bubble into the MEM/WB register.
- `valid_mem` in 1: MEM-stage instruction is valid.
- `reg_write_mem` in 1: instruction writes the register file.
- `res_sel_mem` in 2: result source; 00 = ALU, 01 = memory, 10 = link, 11 = ALU.
- `load_type_mem` in 3: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; any other code = lw.
- `read_data` in 32: raw data-memory word.
- `address_mem` in 32: ALU result / memory address.
- `link_mem` in 32: PC+8 for jal/jalr.
- `write_register_mem` in `REG_ADDR_W`: destination register.
- `write_data_reg` out 32: data to the register file.
- `write_register` out `REG_ADDR_W`: destination to the register file.
- `reg_write` out 1: register-file write enable.
- `valid_wb` out 1: the WB register holds a valid instruction.
- `prev_valid` out 1: the history entry is valid.
- `prev_write_register` out `REG_ADDR_W`: register of the last committed write.
- `prev_write_data` out 32: data of the last committed write.
- `retired_count` out `CNT_W`: number of instructions retired.

## Operation
MEM/WB register update, evaluated at each rising `clk` edge:
- **Flush (highest priority):** `valid_r`=0. All other fields are don't-care but are cleared to 0.
- **Stall (no flush):** all fields hold.
- **Otherwise:** capture `valid_mem`, `reg_write_mem`, `res_sel_mem`, `load_type_mem`, `read_data`, `address_mem[1:0]`, the full `address_mem`, `link_mem` and `write_register_mem`.

Load formatting (combinational from the registered fields):
- Byte offset `b` = `addr_r[1:0]`. With `BIG_ENDIAN`=1, lane index = 3−`b`.
- Halfword select = `addr_r[1]`, inverted when `BIG_ENDIAN`=1.
- lb / lh: sign-extend the selected byte or halfword to 32 bits.
- lbu / lhu: zero-extend.
- lw: pass the word through.
- An unaligned lw or lh is not checked; the low address bits are ignored for that width.

Output equations:
- `write_data_reg` = formatted load when `sel_r`=01, `link_r` when `sel_r`=10, ALU value otherwise.
- `write_register` = registered destination.
- `reg_write` = `valid_r` & `reg_write_r` & (`write_register` != 0).
- `valid_wb` = `valid_r`.

History entry:
- At an edge where `reg_write`=1 and `stall`=0, load `prev_write_register`/`prev_write_data` with the current outputs and set `prev_valid`=1.
- Otherwise the entry holds. It is not cleared by flush.

Retired counter:
- Increments by 1 at an edge where `valid_r`=1 and `stall`=0, regardless of `reg_write`. This counts each instruction once, as it leaves WB.
- Wraps from 2^`CNT_W`−1 to 0.
- A flush does not cancel the instruction currently in WB: it retires at that edge if `stall`=0.
- With `stall` and `flush` both high, `valid_r` becomes 0 and the departing instruction is not counted.

Reset:
- Asynchronous; takes effect immediately.
- Every register clears to 0. All outputs read 0, including `retired_count` and `prev_valid`.
- Reset mid-stall discards the held instruction.

## Timing
- Latency is 1 cycle: MEM inputs at edge N appear on the WB outputs after edge N.
- `write_data_reg`, `write_register` and `reg_write` are combinational from registers only. There is no input-to-output combinational path.
- `stall` and `flush` are sampled only at rising edges.
- The register file writes on the same edge that updates the history. The history therefore presents the value the register file has just committed for one cycle and beyond.
- While stalled, `reg_write` stays asserted. The register file rewrites the same value, which is harmless.

## Test plan
1. **Sub-word loads:** `res_sel_mem`=01, `read_data`=0x80FF7F01, `BIG_ENDIAN`=0.
   - lb with `address_mem`=0x3 → 0xFFFFFF80.
   - lbu with offset 0x2 → 0x000000FF.
   - lh with offset 0x2 → 0xFFFF80FF.
   - lhu with offset 0x0 → 0x00007F01.
   - lw → 0x80FF7F01.
   - With `BIG_ENDIAN`=1, lb at offset 0x0 → 0xFFFFFF80.
2. **Source select and `$0` suppression:**
   - ALU 0x1234, `res_sel_mem`=00, dest 5 → `write_data_reg`=0x1234, `reg_write`=1 one cycle later.
   - Link 0x400008, `res_sel_mem`=10, dest 31 → 0x400008.
   - Dest 0 → `reg_write`=0.
3. **Stall and flush:**
   - Stall for 3 cycles → outputs hold, `retired_count` unchanged.
   - Flush → `valid_wb`=0, `reg_write`=0 next cycle.
   - Stall+flush together → bubble loaded, no count.
4. **History:** write r7=0xDEAD, then an instruction with `reg_write`=0 → `prev_valid`=1, `prev_write_register`=7, `prev_write_data`=0xDEAD retained.
5. **Counter wrap:** `CNT_W`=4, retire 17 valid instructions → `retired_count`=1.
6. **Asynchronous reset:** assert `rst` between clock edges mid-stream → all outputs 0 immediately. After release, the first instruction appears after one edge.

Source files
------------

// File: rtl/wb_stage_p.sv
// MIPS R2000 write-back stage: MEM/WB register, sub-word load formatting,
// result select, last-write history for ID bypass and a retired-instruction counter.
module wb_stage_p #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_mem,
    input  logic                  reg_write_mem,
    input  logic [1:0]            res_sel_mem,
    input  logic [2:0]            load_type_mem,
    input  logic [31:0]           read_data,
    input  logic [31:0]           address_mem,
    input  logic [31:0]           link_mem,
    input  logic [REG_ADDR_W-1:0] write_register_mem,
    output logic [31:0]           write_data_reg,
    output logic [REG_ADDR_W-1:0] write_register,
    output logic                  reg_write,
    output logic                  valid_wb,
    output logic                  prev_valid,
    output logic [REG_ADDR_W-1:0] prev_write_register,
    output logic [31:0]           prev_write_data,
    output logic [CNT_W-1:0]      retired_count
);

    localparam logic BE_L = (BIG_ENDIAN != 0);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0]            load_type_q, load_type_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           link_q, link_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [REG_ADDR_W-1:0] prev_reg_q, prev_reg_d;
    logic [31:0]           prev_data_q, prev_data_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [1:0]            lane_s;
    logic [7:0]            byte_s;
    logic                  half_hi_s;
    logic [15:0]           half_s;
    logic [31:0]           load_s;
    logic [31:0]           wdata_s;
    logic                  reg_write_s;

    // MEM/WB register next state: flush beats stall beats capture
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        sel_d       = sel_q;
        load_type_d = load_type_q;
        rdata_d     = rdata_q;
        off_d       = off_q;
        addr_d      = addr_q;
        link_d      = link_q;
        wreg_d      = wreg_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            sel_d       = 2'b00;
            load_type_d = 3'b000;
            rdata_d     = 32'h0000_0000;
            off_d       = 2'b00;
            addr_d      = 32'h0000_0000;
            link_d      = 32'h0000_0000;
            wreg_d      = {REG_ADDR_W{1'b0}};
        end else if (!stall) begin
            valid_d     = valid_mem;
            reg_write_d = reg_write_mem;
            sel_d       = res_sel_mem;
            load_type_d = load_type_mem;
            rdata_d     = read_data;
            off_d       = address_mem[1:0];
            addr_d      = address_mem;
            link_d      = link_mem;
            wreg_d      = write_register_mem;
        end else begin
            valid_d = valid_q;
        end
    end

    // Sub-word load extraction from the registered word
    always_comb begin
        lane_s    = BE_L ? (2'd3 - off_q) : off_q;
        half_hi_s = off_q[1] ^ BE_L;
        half_s    = half_hi_s ? rdata_q[31:16] : rdata_q[15:0];
        case (lane_s)
            2'd0:    byte_s = rdata_q[7:0];
            2'd1:    byte_s = rdata_q[15:8];
            2'd2:    byte_s = rdata_q[23:16];
            2'd3:    byte_s = rdata_q[31:24];
            default: byte_s = rdata_q[7:0];
        endcase
        case (load_type_q)
            3'b001:  load_s = {{16{half_s[15]}}, half_s};
            3'b010:  load_s = {16'h0000, half_s};
            3'b011:  load_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_s = {24'h00_0000, byte_s};
            default: load_s = rdata_q;
        endcase
    end

    // Result source select and $0 write suppression
    always_comb begin
        case (sel_q)
            2'b01:   wdata_s = load_s;
            2'b10:   wdata_s = link_q;
            default: wdata_s = addr_q;
        endcase
        reg_write_s = valid_q & reg_write_q & (wreg_q != {REG_ADDR_W{1'b0}});
    end

    // History tracks the register-file commit; the counter retires on leaving WB
    always_comb begin
        prev_valid_d = prev_valid_q;
        prev_reg_d   = prev_reg_q;
        prev_data_d  = prev_data_q;
        count_d      = count_q;
        if (reg_write_s && !stall) begin
            prev_valid_d = 1'b1;
            prev_reg_d   = wreg_q;
            prev_data_d  = wdata_s;
        end else begin
            prev_valid_d = prev_valid_q;
        end
        if (valid_q && !stall) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            sel_q        <= 2'b00;
            load_type_q  <= 3'b000;
            rdata_q      <= 32'h0000_0000;
            off_q        <= 2'b00;
            addr_q       <= 32'h0000_0000;
            link_q       <= 32'h0000_0000;
            wreg_q       <= {REG_ADDR_W{1'b0}};
            prev_valid_q <= 1'b0;
            prev_reg_q   <= {REG_ADDR_W{1'b0}};
            prev_data_q  <= 32'h0000_0000;
            count_q      <= {CNT_W{1'b0}};
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            sel_q        <= sel_d;
            load_type_q  <= load_type_d;
            rdata_q      <= rdata_d;
            off_q        <= off_d;
            addr_q       <= addr_d;
            link_q       <= link_d;
            wreg_q       <= wreg_d;
            prev_valid_q <= prev_valid_d;
            prev_reg_q   <= prev_reg_d;
            prev_data_q  <= prev_data_d;
            count_q      <= count_d;
        end
    end

    assign write_data_reg      = wdata_s;
    assign write_register      = wreg_q;
    assign reg_write           = reg_write_s;
    assign valid_wb            = valid_q;
    assign prev_valid          = prev_valid_q;
    assign prev_write_register = prev_reg_q;
    assign prev_write_data     = prev_data_q;
    assign retired_count       = count_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Directed bench for wb_stage_p: default, big-endian and 4-bit-counter instances
// share one stimulus stream and are checked against hand-computed values.
module tb_wb_stage_p;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_mem;
    logic        reg_write_mem;
    logic [1:0]  res_sel_mem;
    logic [2:0]  load_type_mem;
    logic [31:0] read_data;
    logic [31:0] address_mem;
    logic [31:0] link_mem;
    logic [4:0]  write_register_mem;

    logic [31:0] wd_a, wd_b, wd_c;
    logic [4:0]  wr_a, wr_b, wr_c;
    logic        rw_a, rw_b, rw_c;
    logic        vw_a, vw_b, vw_c;
    logic        pv_a, pv_b, pv_c;
    logic [4:0]  pr_a, pr_b, pr_c;
    logic [31:0] pd_a, pd_b, pd_c;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
    logic [3:0]  cnt_c;

    int checks;
    int failures;

    wb_stage_p dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_mem(valid_mem), .reg_write_mem(reg_write_mem),
        .res_sel_mem(res_sel_mem), .load_type_mem(load_type_mem),
        .read_data(read_data), .address_mem(address_mem), .link_mem(link_mem),
        .write_register_mem(write_register_mem),
        .write_data_reg(wd_a), .write_register(wr_a), .reg_write(rw_a),
        .valid_wb(vw_a), .prev_valid(pv_a), .prev_write_register(pr_a),
        .prev_write_data(pd_a), .retired_count(cnt_a)
    );

    wb_stage_p #(.BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_mem(valid_mem), .reg_write_mem(reg_write_mem),
        .res_sel_mem(res_sel_mem), .load_type_mem(load_type_mem),
        .read_data(read_data), .address_mem(address_mem), .link_mem(link_mem),
        .write_register_mem(write_register_mem),
        .write_data_reg(wd_b), .write_register(wr_b), .reg_write(rw_b),
        .valid_wb(vw_b), .prev_valid(pv_b), .prev_write_register(pr_b),
        .prev_write_data(pd_b), .retired_count(cnt_b)
    );

    wb_stage_p #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_mem(valid_mem), .reg_write_mem(reg_write_mem),
        .res_sel_mem(res_sel_mem), .load_type_mem(load_type_mem),
        .read_data(read_data), .address_mem(address_mem), .link_mem(link_mem),
        .write_register_mem(write_register_mem),
        .write_data_reg(wd_c), .write_register(wr_c), .reg_write(rw_c),
        .valid_wb(vw_c), .prev_valid(pv_c), .prev_write_register(pr_c),
        .prev_write_data(pd_c), .retired_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] rd,
                         input logic [31:0] addr, input logic [31:0] lnk,
                         input logic [4:0] dest, input logic rw);
        valid_mem          = 1'b1;
        reg_write_mem      = rw;
        res_sel_mem        = sel;
        load_type_mem      = lt;
        read_data          = rd;
        address_mem        = addr;
        link_mem           = lnk;
        write_register_mem = dest;
    endtask

    task automatic idle();
        valid_mem          = 1'b0;
        reg_write_mem      = 1'b0;
        res_sel_mem        = 2'b00;
        load_type_mem      = 3'b000;
        read_data          = 32'h0;
        address_mem        = 32'h0;
        link_mem           = 32'h0;
        write_register_mem = 5'd0;
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_wd", wd_a, 32'h0);
        chk("rst_rw", {31'd0, rw_a}, 32'd0);
        chk("rst_vwb", {31'd0, vw_a}, 32'd0);
        chk("rst_pv", {31'd0, pv_a}, 32'd0);
        chk("rst_cnt", cnt_a, 32'd0);
        rst = 1'b0;

        // sub-word loads, little- and big-endian instances side by side
        issue(2'b01, 3'b011, RD, 32'h3, 32'h0, 5'd2, 1'b1); tick();
        chk("lb_off3", wd_a, 32'hFFFFFF80);
        chk("be_lb_off3", wd_b, 32'h00000001);
        issue(2'b01, 3'b100, RD, 32'h2, 32'h0, 5'd2, 1'b1); tick();
        chk("lbu_off2", wd_a, 32'h000000FF);
        issue(2'b01, 3'b001, RD, 32'h2, 32'h0, 5'd2, 1'b1); tick();
        chk("lh_off2", wd_a, 32'hFFFF80FF);
        chk("be_lh_off2", wd_b, 32'h00007F01);
        issue(2'b01, 3'b010, RD, 32'h0, 32'h0, 5'd2, 1'b1); tick();
        chk("lhu_off0", wd_a, 32'h00007F01);
        issue(2'b01, 3'b000, RD, 32'h0, 32'h0, 5'd2, 1'b1); tick();
        chk("lw", wd_a, 32'h80FF7F01);
        issue(2'b01, 3'b011, RD, 32'h0, 32'h0, 5'd2, 1'b1); tick();
        chk("lb_off0", wd_a, 32'h00000001);
        chk("be_lb_off0", wd_b, 32'hFFFFFF80);
        chk("cnt_after_loads", cnt_a, 32'd5);

        // source select and $0 suppression
        issue(2'b00, 3'b000, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1); tick();
        chk("alu_wd", wd_a, 32'h00001234);
        chk("alu_rw", {31'd0, rw_a}, 32'd1);
        chk("alu_wr", {27'd0, wr_a}, 32'd5);
        issue(2'b10, 3'b000, 32'h0, 32'hFFFF, 32'h400008, 5'd31, 1'b1); tick();
        chk("link_wd", wd_a, 32'h00400008);
        issue(2'b00, 3'b000, 32'h0, 32'h55, 32'h0, 5'd0, 1'b1); tick();
        chk("r0_rw", {31'd0, rw_a}, 32'd0);
        chk("r0_vwb", {31'd0, vw_a}, 32'd1);

        // history across a non-writing instruction
        issue(2'b00, 3'b000, 32'h0, 32'hDEAD, 32'h0, 5'd7, 1'b1); tick();
        chk("r7_rw", {31'd0, rw_a}, 32'd1);
        chk("hist_prev_r31", {27'd0, pr_a}, 32'd31);
        issue(2'b00, 3'b000, 32'h0, 32'hBEEF, 32'h0, 5'd8, 1'b0); tick();
        chk("nowr_rw", {31'd0, rw_a}, 32'd0);
        chk("hist_pv", {31'd0, pv_a}, 32'd1);
        chk("hist_reg", {27'd0, pr_a}, 32'd7);
        chk("hist_data", pd_a, 32'h0000DEAD);
        idle(); tick();
        chk("hist_keep_data", pd_a, 32'h0000DEAD);
        chk("cnt_hist", cnt_a, 32'd11);

        // stall holds everything, including history and counter
        issue(2'b00, 3'b000, 32'h0, 32'h77, 32'h0, 5'd9, 1'b1); tick();
        stall = 1'b1;
        issue(2'b00, 3'b000, 32'h0, 32'h99, 32'h0, 5'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wd", wd_a, 32'h00000077);
            chk("stall_rw", {31'd0, rw_a}, 32'd1);
            chk("stall_cnt", cnt_a, 32'd11);
            chk("stall_hist", {27'd0, pr_a}, 32'd7);
        end
        stall = 1'b0; tick();
        chk("unstall_wd", wd_a, 32'h00000099);
        chk("unstall_cnt", cnt_a, 32'd12);
        chk("unstall_hist", {27'd0, pr_a}, 32'd9);

        // flush: bubble loaded, departing instruction still retires
        flush = 1'b1;
        issue(2'b00, 3'b000, 32'h0, 32'hAA, 32'h0, 5'd11, 1'b1); tick();
        flush = 1'b0;
        chk("flush_vwb", {31'd0, vw_a}, 32'd0);
        chk("flush_rw", {31'd0, rw_a}, 32'd0);
        chk("flush_wd", wd_a, 32'h0);
        chk("flush_cnt", cnt_a, 32'd13);
        chk("flush_hist", pd_a, 32'h00000099);

        // stall and flush together: bubble, no count, no history update
        issue(2'b00, 3'b000, 32'h0, 32'hBB, 32'h0, 5'd12, 1'b1); tick();
        chk("pre_sf_vwb", {31'd0, vw_a}, 32'd1);
        stall = 1'b1; flush = 1'b1; tick();
        stall = 1'b0; flush = 1'b0;
        chk("sf_vwb", {31'd0, vw_a}, 32'd0);
        chk("sf_cnt", cnt_a, 32'd13);
        chk("sf_hist", pd_a, 32'h00000099);
        idle(); tick();
        chk("sf_cnt_after", cnt_a, 32'd13);

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, 3'b000, 32'h0, 32'h10 + i, 32'h0, 5'd1, 1'b1); tick();
        end
        chk("c4_wrap0", {28'd0, cnt_c}, 32'd0);
        idle(); tick();
        chk("c4_wrap1", {28'd0, cnt_c}, 32'd1);
        chk("cnt_17", cnt_a, 32'd17);

        // asynchronous reset between edges
        issue(2'b00, 3'b000, 32'h0, 32'h33, 32'h0, 5'd3, 1'b1); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_vwb", {31'd0, vw_a}, 32'd0);
        chk("arst_rw", {31'd0, rw_a}, 32'd0);
        chk("arst_wd", wd_a, 32'h0);
        chk("arst_cnt", cnt_a, 32'd0);
        chk("arst_pv", {31'd0, pv_a}, 32'd0);
        chk("arst_pd", pd_a, 32'h0);
        #2 rst = 1'b0;
        issue(2'b00, 3'b000, 32'h0, 32'h4242, 32'h0, 5'd4, 1'b1); tick();
        chk("post_rst_vwb", {31'd0, vw_a}, 32'd1);
        chk("post_rst_wd", wd_a, 32'h00004242);
        chk("post_rst_cnt", cnt_a, 32'd0);
        idle(); tick();
        chk("post_rst_cnt1", cnt_a, 32'd1);
        chk("post_rst_hist", pd_a, 32'h00004242);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
